// File: rtl/spmmio_dbg_pkg.sv
// Shared constants and state encoding for the SP MMIO debug bus master.
package spmmio_dbg_pkg;

    localparam logic [3:0] OP_SYNC  = 4'h0;
    localparam logic [3:0] OP_READ  = 4'h1;
    localparam logic [3:0] OP_WRITE = 4'h2;

    localparam logic [7:0] RSP_SYNC   = 8'hA5;
    localparam logic [7:0] RSP_BADOP  = 8'hEE;
    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_TIMEOUT = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADR,
        S_WDAT,
        S_BUS,
        S_RSTAT,
        S_RDAT,
        S_RBYTE
    } state_t;

endpackage

// File: rtl/spmmio_dbg_master.sv
// Byte-stream debug command interpreter issuing single Wishbone cycles on the
// SP MMIO bus and streaming back status and read data.
module spmmio_dbg_master
    import spmmio_dbg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:7]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [0:7]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [0:23] adr_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic [0:3]  sel_o,
    output logic        we_o,
    output logic [0:31] dat_o,
    input  logic [0:31] dat_i,
    input  logic        ack_i,
    output logic        busy
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic [1:0]  cnt, cnt_n;
    logic [15:0] tcnt;
    logic [0:31] rdata;
    logic [7:0]  status;
    logic [7:0]  rbyte;
    logic [3:0]  op_hi;
    logic        rx_fire;
    logic        tx_fire;
    logic        timeout_hit;
    logic        is_cmd;

    assign op_hi       = rx_data[0:3];
    assign is_cmd      = (op_hi == OP_READ) || (op_hi == OP_WRITE);
    assign rx_ready    = (state inside {S_IDLE, S_ADR, S_WDAT}) && !reset;
    assign tx_valid    = state inside {S_RSTAT, S_RDAT, S_RBYTE};
    assign rx_fire     = rx_valid && rx_ready;
    assign tx_fire     = tx_valid && tx_ready;
    assign timeout_hit = (tcnt == TO_LAST);
    assign busy        = (state != S_IDLE);
    // BUS is entered on a clock edge, so the strobe is effectively registered.
    assign cyc_o       = (state == S_BUS);
    assign stb_o       = (state == S_BUS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tx_data = 8'h00;
        case (state)
            S_IDLE: begin
                if (rx_fire) begin
                    cnt_n   = 2'd0;
                    state_n = (rx_data != 8'h00 && is_cmd) ? S_ADR : S_RBYTE;
                end
            end
            S_ADR: begin
                if (rx_fire) begin
                    if (cnt == 2'd2) begin
                        cnt_n   = 2'd0;
                        state_n = we_o ? S_WDAT : S_BUS;
                    end else begin
                        cnt_n = cnt + 2'd1;
                    end
                end
            end
            S_WDAT: begin
                if (rx_fire) begin
                    if (cnt == 2'd3) begin
                        cnt_n   = 2'd0;
                        state_n = S_BUS;
                    end else begin
                        cnt_n = cnt + 2'd1;
                    end
                end
            end
            S_BUS: begin
                // An ack on the final timeout cycle still counts as success.
                if (ack_i || timeout_hit) state_n = S_RSTAT;
            end
            S_RSTAT: begin
                tx_data = status;
                if (tx_fire) begin
                    cnt_n   = 2'd0;
                    state_n = we_o ? S_IDLE : S_RDAT;
                end
            end
            S_RDAT: begin
                case (cnt)
                    2'd0:    tx_data = rdata[0:7];
                    2'd1:    tx_data = rdata[8:15];
                    2'd2:    tx_data = rdata[16:23];
                    default: tx_data = rdata[24:31];
                endcase
                if (tx_fire) begin
                    if (cnt == 2'd3) begin
                        cnt_n   = 2'd0;
                        state_n = S_IDLE;
                    end else begin
                        cnt_n = cnt + 2'd1;
                    end
                end
            end
            S_RBYTE: begin
                tx_data = rbyte;
                if (tx_fire) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_o   <= 1'b0;
            sel_o  <= 4'h0;
            adr_o  <= 24'h0;
            dat_o  <= 32'h0;
            rdata  <= 32'h0;
            status <= ST_OK;
            rbyte  <= 8'h00;
            tcnt   <= 16'd0;
        end else begin
            tcnt <= (state == S_BUS) ? tcnt + 16'd1 : 16'd0;
            case (state)
                S_IDLE: begin
                    if (rx_fire) begin
                        if (rx_data == 8'h00) begin
                            rbyte <= RSP_SYNC;
                        end else if (is_cmd) begin
                            we_o  <= (op_hi == OP_WRITE);
                            sel_o <= rx_data[4:7];
                        end else begin
                            rbyte <= RSP_BADOP;
                        end
                    end
                end
                S_ADR: begin
                    // Last address byte drops its two low bits: word-aligned bus.
                    if (rx_fire) begin
                        if (cnt == 2'd2) adr_o <= {adr_o[8:23], rx_data[0:5], 2'b00};
                        else             adr_o <= {adr_o[8:23], rx_data};
                    end
                end
                S_WDAT: begin
                    if (rx_fire) dat_o <= {dat_o[8:31], rx_data};
                end
                S_BUS: begin
                    if (ack_i) begin
                        status <= ST_OK;
                        if (!we_o) rdata <= dat_i;
                    end else if (timeout_hit) begin
                        status <= ST_TIMEOUT;
                        rdata  <= 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spmmio_dbg_master.sv
// Randomized self-checking bench for spmmio_dbg_master with a transaction-level model.
module tb_spmmio_dbg_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [23:0] adr_o;
    logic        cyc_o;
    logic        stb_o;
    logic [3:0]  sel_o;
    logic        we_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        busy;

    always #5 clk = ~clk;

    spmmio_dbg_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .adr_o(adr_o), .cyc_o(cyc_o), .stb_o(stb_o), .sel_o(sel_o), .we_o(we_o),
        .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .busy(busy)
    );

    typedef struct {
        logic [23:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          len;
    } txn_t;

    typedef struct {
        int          delay;
        logic [31:0] val;
    } slv_t;

    int   checks = 0;
    int   failures = 0;
    txn_t exp_bus[$];
    logic [7:0] exp_tx[$];
    logic [7:0] obs[$];
    slv_t slv_q[$];
    int   tx_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave: acks once the strobe has been high for 'delay' completed cycles.
    int          scnt = 0;
    logic        stb_prev = 1'b0;
    int          cur_delay = 1 << 30;
    logic [31:0] cur_val = 32'h0;

    assign ack_i = stb_o && (scnt >= cur_delay);
    assign dat_i = cur_val;

    always @(posedge clk) begin
        scnt     <= stb_o ? scnt + 1 : 0;
        stb_prev <= stb_o;
        if (stb_prev && !stb_o && slv_q.size() > 0) begin
            void'(slv_q.pop_front());
            if (slv_q.size() > 0) begin
                cur_delay = slv_q[0].delay;
                cur_val   = slv_q[0].val;
            end else begin
                cur_delay = 1 << 30;
                cur_val   = 32'h0;
            end
        end
    end

    task automatic push_slave(input int d, input logic [31:0] v);
        if (slv_q.size() == 0) begin
            cur_delay = d;
            cur_val   = v;
        end
        slv_q.push_back('{delay: d, val: v});
    endtask

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (tx_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // Compare process.
    logic        rst_q = 1'b0;
    logic        in_cyc = 1'b0;
    logic        cur_ok = 1'b0;
    logic        hold = 1'b0;
    logic [7:0]  hold_data = 8'h00;
    int          cyc_len = 0;
    int          n_bus = 0;
    txn_t        cur;
    logic [23:0] last_adr = 24'h0;
    logic        last_we = 1'b0;
    logic [3:0]  last_sel = 4'h0;
    logic [31:0] last_dat = 32'h0;
    int          last_len = 0;

    always @(posedge clk) rst_q <= reset;

    always @(negedge clk) begin
        if (reset) begin
            exp_tx.delete();
            exp_bus.delete();
            in_cyc = 1'b0;
            hold   = 1'b0;
            if (rst_q) begin
                chk("reset_ctl", {14'd0, rx_ready, tx_valid, cyc_o, stb_o, we_o, busy, sel_o, tx_data}, 32'h0);
                chk("reset_adr", {8'd0, adr_o}, 32'h0);
                chk("reset_dat", dat_o, 32'h0);
            end
        end else begin
            if (hold) begin
                chk("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
                chk("tx_hold_data", {24'd0, tx_data}, {24'd0, hold_data});
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected: got %h expected no byte", tx_data);
                end else begin
                    chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
                end
                obs.push_back(tx_data);
            end
            hold      = tx_valid && !tx_ready;
            hold_data = tx_data;
            chk("rx_held_off", {31'd0, rx_ready && (tx_valid || cyc_o)}, 32'd0);
            chk("stb_eq_cyc", {31'd0, stb_o}, {31'd0, cyc_o});
            if (cyc_o) begin
                if (!in_cyc) begin
                    in_cyc  = 1'b1;
                    cyc_len = 0;
                    n_bus++;
                    cur_ok  = (exp_bus.size() > 0);
                    if (cur_ok) cur = exp_bus.pop_front();
                    else begin
                        checks++;
                        failures++;
                        $display("FAIL bus_unexpected: got cycle at adr %h expected none", adr_o);
                    end
                end
                cyc_len++;
                last_adr = adr_o;
                last_we  = we_o;
                last_sel = sel_o;
                last_dat = dat_o;
                if (cur_ok) begin
                    chk("bus_adr", {8'd0, adr_o}, {8'd0, cur.adr});
                    chk("bus_we", {31'd0, we_o}, {31'd0, cur.we});
                    chk("bus_sel", {28'd0, sel_o}, {28'd0, cur.sel});
                    if (cur.we) chk("bus_dat", dat_o, cur.dat);
                end
            end else if (in_cyc) begin
                in_cyc   = 1'b0;
                last_len = cyc_len;
                if (cur_ok) chk("bus_len", cyc_len, cur.len);
            end
        end
    end

    // Stimulus helpers.
    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int n = 0; n < 1000 && !ok; n++) begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        rx_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL rx_accept: byte %h not taken, required acceptance within 1000 cycles", b);
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk);
            if (!busy && !in_cyc && exp_tx.size() == 0 && exp_bus.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: busy=%0d pending_tx=%0d required idle within 3000 cycles",
                     busy, exp_tx.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cmd_sync();
        exp_tx.push_back(8'hA5);
        send_byte(8'h00);
    endtask

    task automatic cmd_bad(input logic [7:0] b);
        exp_tx.push_back(8'hEE);
        send_byte(b);
    endtask

    task automatic cmd_read(input logic [3:0] s, input logic [23:0] a, input int d, input logic [31:0] v);
        bit          ok  = (d < TO);
        logic [31:0] r   = ok ? v : 32'h0;
        exp_bus.push_back('{adr: {a[23:2], 2'b00}, we: 1'b0, sel: s, dat: 32'h0, len: ok ? d + 1 : TO});
        push_slave(d, v);
        exp_tx.push_back(ok ? 8'h00 : 8'h01);
        exp_tx.push_back(r[31:24]);
        exp_tx.push_back(r[23:16]);
        exp_tx.push_back(r[15:8]);
        exp_tx.push_back(r[7:0]);
        send_byte({4'h1, s});
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic cmd_write(input logic [3:0] s, input logic [23:0] a, input logic [31:0] w, input int d);
        bit ok = (d < TO);
        exp_bus.push_back('{adr: {a[23:2], 2'b00}, we: 1'b1, sel: s, dat: w, len: ok ? d + 1 : TO});
        push_slave(d, 32'h0);
        exp_tx.push_back(ok ? 8'h00 : 8'h01);
        send_byte({4'h2, s});
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic chk_obs(input string name, input int n, input logic [39:0] v);
        chk({name, "_count"}, obs.size(), n);
        for (int i = 0; i < n && i < obs.size(); i++)
            chk(name, {24'd0, obs[i]}, {24'd0, v[8*(n-1-i) +: 8]});
    endtask

    function automatic int rand_delay();
        int r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(0, 3);
        if (r < 8) return $urandom_range(5, 9);
        return 1000;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, required completion within 40000 cycles");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int nb;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_rx_ready", {31'd0, rx_ready}, 32'd1);
        @(posedge clk);
        #1;

        // SYNC
        obs.delete();
        nb = n_bus;
        cmd_sync();
        wait_idle();
        chk_obs("sync_rsp", 1, 40'hA5);
        chk("sync_no_bus", n_bus, nb);

        // READ with combinational ack
        obs.delete();
        cmd_read(4'hF, 24'h000010, 0, 32'h12345678);
        wait_idle();
        chk_obs("read_rsp", 5, 40'h0012345678);
        chk("read_len", last_len, 1);
        chk("read_adr", {8'd0, last_adr}, 32'h000010);
        chk("read_we", {31'd0, last_we}, 32'd0);
        chk("read_sel", {28'd0, last_sel}, 32'hF);

        // WRITE, low address bits cleared
        obs.delete();
        cmd_write(4'h3, 24'h020007, 32'hDEADBEEF, 0);
        wait_idle();
        chk_obs("write_rsp", 1, 40'h00);
        chk("write_adr", {8'd0, last_adr}, 32'h020004);
        chk("write_we", {31'd0, last_we}, 32'd1);
        chk("write_sel", {28'd0, last_sel}, 32'h3);
        chk("write_dat", last_dat, 32'hDEADBEEF);
        chk("write_len", last_len, 1);

        // Timeout, then SYNC still answered
        obs.delete();
        cmd_read(4'hF, 24'h00ABCC, 1000, 32'h55555555);
        wait_idle();
        chk_obs("timeout_rsp", 5, 40'h0100000000);
        chk("timeout_len", last_len, 8);
        obs.delete();
        cmd_sync();
        wait_idle();
        chk_obs("post_timeout_sync", 1, 40'hA5);

        // Ack on the final timeout cycle is a success
        obs.delete();
        cmd_read(4'h2, 24'h000020, 7, 32'hA1B2C3D4);
        wait_idle();
        chk_obs("late_ack_rsp", 5, 40'h00A1B2C3D4);
        chk("late_ack_len", last_len, 8);

        // Invalid opcodes
        obs.delete();
        nb = n_bus;
        cmd_bad(8'h7C);
        cmd_bad(8'h05);
        wait_idle();
        chk_obs("badop_rsp", 2, 40'hEEEE);
        chk("badop_no_bus", n_bus, nb);

        // Back-pressure on the response stream
        obs.delete();
        tx_mode = 2;
        cmd_read(4'h1, 24'h000104, 2, 32'hCAFEF00D);
        for (int n = 0; n < 100 && !tx_valid; n++) @(negedge clk);
        chk("hold_tx_valid", {31'd0, tx_valid}, 32'd1);
        repeat (10) @(negedge clk);
        tx_mode = 0;
        wait_idle();
        chk_obs("hold_rsp", 5, 40'h00CAFEF00D);

        // Reset in the middle of a bus cycle
        cmd_read(4'hF, 24'h000040, 5, 32'h00000001);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        obs.delete();
        cmd_sync();
        wait_idle();
        chk_obs("rst_bus_sync", 1, 40'hA5);

        // Reset after two address bytes
        send_byte(8'h1F);
        send_byte(8'h00);
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        obs.delete();
        cmd_sync();
        wait_idle();
        chk_obs("rst_adr_sync", 1, 40'hA5);

        // Randomized command stream
        for (int i = 0; i < 80; i++) begin
            int k = $urandom_range(0, 9);
            tx_mode = $urandom_range(0, 1);
            if (k == 0) cmd_sync();
            else if (k == 1) begin
                logic [7:0] b;
                do b = 8'($urandom_range(1, 255)); while (b[7:4] == 4'h1 || b[7:4] == 4'h2);
                cmd_bad(b);
            end else if (k < 6) cmd_read(4'($urandom), 24'($urandom), rand_delay(), $urandom);
            else cmd_write(4'($urandom), 24'($urandom), $urandom, rand_delay());
            if ($urandom_range(0, 1) == 0) wait_idle();
        end
        tx_mode = 0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spmmio_dbg_master.md
Name: spmmio_dbg_master

Overview:
Wishbone initiator that turns a byte-stream debug command protocol into single Wishbone cycles on the SP MMIO bus, then returns status and read data as a byte stream. It is the bus-master counterpart to the MMIO address decoder. A debug UART or JTAG byte link can drive it to peek and poke SP peripherals without the soft CPU. It issues one transaction at a time, with a timeout guard against slaves that never ack.

Parameters:
TIMEOUT_CYCLES, 255, cycles in BUS without ack before the cycle is aborted (1..65535)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_data  in  [0:7]  command byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  byte accepted when rx_valid && rx_ready at clk edge
tx_data  out  [0:7]  response byte
tx_valid  out  1  response byte valid
tx_ready  in  1  consumer accepts tx_data at clk edge
adr_o  out  [0:23]  Wishbone address, bit 21 is LSB, bits 22..23 always 0
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
sel_o  out  [0:3]  byte selects, sel_o[0] = dat bits 0..7
we_o  out  1  write enable
dat_o  out  [0:31]  write data
dat_i  in  [0:31]  read data
ack_i  in  1  slave ack (may be combinational from stb_o)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: rx_ready=0, tx_valid=0, tx_data=0, cyc_o=0, stb_o=0, we_o=0, sel_o=0, adr_o=0, dat_o=0, busy=0, state=IDLE. Reset mid-operation drops cyc_o/stb_o at that edge and discards any partial command or pending response.
- Opcode byte, with s = low nibble:
  - 0x00: SYNC. Response is the single byte 0xA5.
  - 0x1s: READ with sel=s. Followed by 3 address bytes.
  - 0x2s: WRITE with sel=s. Followed by 3 address bytes, then 4 data bytes.
  - Any other value: response is the single byte 0xEE; no bus cycle.
- Address bytes are big-endian into adr_o[0:7], [8:15], [16:23], then bits 22..23 are cleared. Data bytes are big-endian into dat_o[0:31].
- FSM states: IDLE, ADR(cnt 0..2), WDAT(cnt 0..3), BUS, RSTAT, RDAT(cnt 0..3), RBYTE.
  - rx_ready=1 only in IDLE, ADR and WDAT; each byte is consumed on the handshake edge.
  - IDLE: SYNC or invalid opcode -> RBYTE. READ -> ADR. WRITE -> ADR.
  - ADR, after 3rd byte: READ -> BUS, WRITE -> WDAT. WDAT, after 4th byte -> BUS.
  - BUS: cyc_o=stb_o=1 registered from the entry edge, so the first bus cycle is the cycle after the last byte is accepted. we_o and sel_o are held stable.
    - ack_i sampled 1: capture dat_i (reads only), drop cyc_o/stb_o at the same edge, status=0x00 -> RSTAT. A combinationally acking slave therefore gives exactly one cycle of stb_o.
    - Timeout counter reset on BUS entry; when it reaches TIMEOUT_CYCLES with no ack: drop cyc_o/stb_o, status=0x01, read data forced to 0 -> RSTAT.
    - ack_i arriving on the timeout cycle counts as success.
  - RSTAT: tx_valid=1 with status. On tx_ready: WRITE -> IDLE, READ -> RDAT.
  - RDAT: sends captured data bytes 0..3 MSB-first, then -> IDLE.
  - RBYTE: sends 0xA5 or 0xEE, then -> IDLE.
  - tx_data/tx_valid stay stable until accepted. The byte counter increments only on handshake and wraps to IDLE after the last byte.
- ack_i outside BUS is ignored. rx_valid outside the accepting states is not consumed; it is held off by rx_ready=0.
- Throughput: a READ with an always-ready source/sink takes 4 rx cycles + 1 BUS + 5 tx cycles.

Decomposition:
- Shared package spmmio_dbg_pkg holds:
  - opcode constants OP_SYNC=0x0, OP_READ=0x1, OP_WRITE=0x2 (high nibble);
  - response constants RSP_SYNC=0xA5, RSP_BADOP=0xEE, ST_OK=0x00, ST_TIMEOUT=0x01;
  - the state enum.
- No sub-module; FSM, shift registers and timeout counter stay in one module.

Test Plan:
- Send 0x00 -> tx exactly 0xA5, no cyc_o activity, busy returns to 0.
- Send 0x1F,0x00,0x00,0x10; model slave acks combinationally with dat_i=0x12345678 -> one cycle stb_o, adr_o=0x000010, we_o=0, sel_o=0xF; tx 0x00,0x12,0x34,0x56,0x78.
- Send 0x23,0x02,0x00,0x07,0xDE,0xAD,0xBE,0xEF -> adr_o=0x020004 (bits 22..23 cleared), we_o=1, sel_o=0x3, dat_o=0xDEADBEEF for one ack; tx 0x00 only.
- READ with slave never acking, TIMEOUT_CYCLES=8 -> cyc_o high exactly 8 cycles; tx 0x01,0x00,0x00,0x00,0x00; a following SYNC still yields 0xA5.
- Send opcode 0x7C -> tx 0xEE, no bus cycle. Then hold tx_ready=0 for 10 cycles during a READ response -> tx_data/tx_valid stable, no byte lost.
- Assert reset in mid-BUS with a slave delaying ack, and again after 2 address bytes -> cyc_o=0 the next cycle, all outputs at reset values, next SYNC answered 0xA5.
